// File: rtl/polyveck_pack_t1_pkg.sv
// Shared Dilithium parameters for the t1 vector packer: vector shape, coefficient
// width, accumulator sizing and the packer FSM encoding.
package polyveck_pack_t1_pkg;

   localparam int K_DEF  = 6;
   localparam int N_DEF  = 256;
   localparam int COEF_W = 10;
   localparam int ACC_W  = 18;
   localparam int FILL_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic int pack_bytes(input int k, input int n);
      return (k * n * COEF_W) / 8;
   endfunction

endpackage

// File: rtl/polyveck_pack_t1_bit_accum_8out.sv
// Bit accumulator: merges 10-bit coefficients LSB-first and emits the low byte;
// a byte pop is applied before a same-cycle merge.
module bit_accum_8out
   import polyveck_pack_t1_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              pop,
   input  logic [COEF_W-1:0] coef,
   output logic [7:0]        acc_byte,
   output logic [FILL_W-1:0] fill
);

   logic [ACC_W-1:0]  acc_reg, acc_shift, acc_next;
   logic [FILL_W-1:0] fill_reg, fill_shift, fill_next;

   always_comb begin
      acc_shift  = pop ? (acc_reg >> 8) : acc_reg;
      fill_shift = pop ? (fill_reg - FILL_W'(8)) : fill_reg;
      acc_next   = acc_shift;
      fill_next  = fill_shift;
      if (load) begin
         acc_next  = acc_shift | (ACC_W'(coef) << fill_shift);
         fill_next = fill_shift + FILL_W'(COEF_W);
      end
      if (clear) begin
         acc_next  = '0;
         fill_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg  <= '0;
         fill_reg <= '0;
      end else begin
         acc_reg  <= acc_next;
         fill_reg <= fill_next;
      end
   end

   assign acc_byte = acc_reg[7:0];
   assign fill     = fill_reg;

endmodule

// File: rtl/polyveck_pack_t1.sv
// Packs a K x N vector of 10-bit t1 coefficients into a byte stream.
// Optional T1_RANGE_CHECK_EN adds a sticky err output for out-of-range inputs.
module polyveck_pack_t1
   import polyveck_pack_t1_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int N = N_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] coef_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
`ifdef T1_RANGE_CHECK_EN
   output logic        err,
`endif
   output logic        done
);

   localparam int TOTAL_COEF  = K * N;
   localparam int TOTAL_BYTES = pack_bytes(K, N);
   localparam int CW          = $clog2(TOTAL_COEF + 1);
   localparam int BW          = $clog2(TOTAL_BYTES + 1);

   state_t            state_reg;
   logic [CW-1:0]     coef_cnt_reg;
   logic [BW-1:0]     byte_cnt_reg;
   logic              busy_reg;
   logic              done_reg;
   logic [FILL_W-1:0] fill;
   logic [7:0]        acc_byte;
   logic              accept;
   logic              xfer;
   logic              clear;

   assign in_ready  = (state_reg == S_RUN) && (fill <= FILL_W'(7)) &&
                      (coef_cnt_reg != CW'(TOTAL_COEF));
   assign out_valid = (fill >= FILL_W'(8));
   assign out_byte  = acc_byte;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign accept    = in_ready && in_valid;
   assign xfer      = out_valid && out_ready;
   assign clear     = (state_reg == S_IDLE) && start;

   bit_accum_8out u_accum (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .load     (accept),
      .pop      (xfer),
      .coef     (coef_in[COEF_W-1:0]),
      .acc_byte (acc_byte),
      .fill     (fill)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         coef_cnt_reg <= '0;
         byte_cnt_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (xfer)
            byte_cnt_reg <= byte_cnt_reg + BW'(1);
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg    <= S_RUN;
                  busy_reg     <= 1'b1;
                  coef_cnt_reg <= '0;
                  byte_cnt_reg <= '0;
               end
            end
            S_RUN: begin
               if (accept) begin
                  coef_cnt_reg <= coef_cnt_reg + CW'(1);
                  if (coef_cnt_reg == CW'(TOTAL_COEF - 1))
                     state_reg <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               // Total bit count is a whole number of bytes, so fill drains to exactly 0.
               if (fill == '0) begin
                  state_reg <= S_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            S_DONE: begin
               state_reg    <= S_IDLE;
               coef_cnt_reg <= '0;
               byte_cnt_reg <= '0;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef T1_RANGE_CHECK_EN
   logic err_reg;

   // Any set bit above bit 9 (including the sign) means the value is outside 0..1023.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_reg <= 1'b0;
      else if (clear)
         err_reg <= 1'b0;
      else if (accept && (coef_in[31:COEF_W] != '0))
         err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   logic unused_hi;
   assign unused_hi = ^coef_in[31:COEF_W];
`endif

endmodule
